// File: rtl/pc_ras_pkg.sv
// Shared types and helpers for the program-counter unit with return-address stack.
package pc_ras_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_BRANCH,
        CMD_LOAD,
        CMD_CALL,
        CMD_RET
    } cmd_e;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Fixed priority: ret > call > enable > branch > IncPC > hold.
    function automatic cmd_e decode_cmd(
        input logic ret,
        input logic call,
        input logic enable,
        input logic branch,
        input logic inc
    );
        if (ret)         return CMD_RET;
        else if (call)   return CMD_CALL;
        else if (enable) return CMD_LOAD;
        else if (branch) return CMD_BRANCH;
        else if (inc)    return CMD_INC;
        else             return CMD_HOLD;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest entry.
module ras_stack
    import pc_ras_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              push_data,
    output logic [WIDTH-1:0]              top_data,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    ptr_inc, ptr_dec;
    logic [CW-1:0]    count_q, count_d;

    // ptr_q is the next free slot; the top entry sits one below it.
    assign ptr_inc   = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec   = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;

    assign top_data  = mem_q[ptr_dec];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign overflow  = push & ~pop & full;
    assign underflow = pop & empty;

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (pop) begin
            if (!empty) begin
                ptr_d   = ptr_dec;
                count_d = count_q - 1'b1;
            end
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_inc;
            if (!full) count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Mini-SRC program counter: increment, load, relative branch and call/return via a RAS.
module pc_ras_unit
    import pc_ras_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter logic [WIDTH-1:0] INIT = '0,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                              clock,
    input  logic                              clear,
    input  logic                              enable,
    input  logic                              IncPC,
    input  logic                              branch,
    input  logic                              call,
    input  logic                              ret,
    input  logic                              err_clr,
    input  logic [WIDTH-1:0]                  BusMuxOut,
    output logic [WIDTH-1:0]                  BusMuxIn,
    output logic [cnt_width(RAS_DEPTH)-1:0]   ras_count,
    output logic                              ras_full,
    output logic                              ras_empty,
    output logic                              ras_err
);

    cmd_e             cmd;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ras_top;
    logic             ras_ovf, ras_unf;

    assign cmd = decode_cmd(ret, call, enable, branch, IncPC);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clock),
        .rst       (clear),
        .push      (cmd == CMD_CALL),
        .pop       (cmd == CMD_RET),
        .push_data (pc_q),
        .top_data  (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    always_comb begin
        pc_d = pc_q;
        case (cmd)
            CMD_INC:    pc_d = pc_q + WIDTH'(STEP);
            CMD_BRANCH: pc_d = pc_q + BusMuxOut;
            CMD_LOAD:   pc_d = BusMuxOut;
            CMD_CALL:   pc_d = BusMuxOut;
            CMD_RET:    pc_d = ras_empty ? pc_q : ras_top;
            default:    pc_d = pc_q;
        endcase
    end

    // A new error in the same cycle beats err_clr.
    always_comb begin
        err_d = err_q;
        if (ras_ovf || ras_unf || (call && ret)) err_d = 1'b1;
        else if (err_clr)                        err_d = 1'b0;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pc_q  <= INIT;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign BusMuxIn = pc_q;
    assign ras_err  = err_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: queue-based reference model plus directed literal checks.
module tb_pc_ras_unit;

    localparam int unsigned    WIDTH = 32;
    localparam logic [31:0]    INIT  = 32'h100;
    localparam int unsigned    STEP  = 1;
    localparam int unsigned    DEPTH = 4;

    logic        clock = 1'b0;
    logic        clear, enable, IncPC, branch, call, ret, err_clr;
    logic [31:0] BusMuxOut;
    logic [31:0] BusMuxIn;
    logic [2:0]  ras_count;
    logic        ras_full, ras_empty, ras_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Reference model: PC, stack as a queue (back = top), sticky error.
    bit [31:0] m_pc;
    bit [31:0] m_ras[$];
    bit        m_err;

    pc_ras_unit #(
        .WIDTH     (WIDTH),
        .INIT      (INIT),
        .STEP      (STEP),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .enable    (enable),
        .IncPC     (IncPC),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .err_clr   (err_clr),
        .BusMuxOut (BusMuxOut),
        .BusMuxIn  (BusMuxIn),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_err   (ras_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = INIT;
        m_ras.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit inc, input bit br, input bit cl,
                              input bit rt, input bit ec, input bit [31:0] bus);
        bit ev = 1'b0;
        if (rt) begin
            if (cl) ev = 1'b1;
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else ev = 1'b1;
        end else if (cl) begin
            m_ras.push_back(m_pc);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                ev = 1'b1;
            end
            m_pc = bus;
        end else if (en)  m_pc = bus;
        else if (br)      m_pc = m_pc + bus;
        else if (inc)     m_pc = m_pc + STEP;
        if (ev)      m_err = 1'b1;
        else if (ec) m_err = 1'b0;
    endtask

    // One command cycle, entered and left just after a falling edge.
    task automatic tick(input bit en, input bit inc, input bit br, input bit cl,
                        input bit rt, input bit ec, input bit [31:0] bus);
        enable = en; IncPC = inc; branch = br; call = cl; ret = rt; err_clr = ec;
        BusMuxOut = bus;
        @(posedge clock);
        model_step(en, inc, br, cl, rt, ec, bus);
        @(negedge clock);
        enable = 0; IncPC = 0; branch = 0; call = 0; ret = 0; err_clr = 0;
    endtask

    task automatic do_clear();
        #2 clear = 1'b1;
        model_reset();
        #1;
        check("async_clear_pc", BusMuxIn, INIT);
        check("async_clear_cnt", 32'(ras_count), 32'd0);
        @(negedge clock);
        clear = 1'b0;
    endtask

    // Literal expectations that pin both the model and the DUT.
    task automatic pin(input string name, input bit [31:0] pc, input int cnt, input bit err);
        check({name, "_model_pc"}, m_pc, pc);
        check({name, "_model_cnt"}, 32'(m_ras.size()), 32'(cnt));
        check({name, "_model_err"}, 32'(m_err), 32'(err));
        check({name, "_pc"}, BusMuxIn, pc);
        check({name, "_cnt"}, 32'(ras_count), 32'(cnt));
        check({name, "_err"}, 32'(ras_err), 32'(err));
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("cyc_pc", BusMuxIn, m_pc);
            check("cyc_cnt", 32'(ras_count), 32'(m_ras.size()));
            check("cyc_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
            check("cyc_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            check("cyc_err", 32'(ras_err), 32'(m_err));
        end
    end

    initial begin
        clear = 1'b1;
        enable = 0; IncPC = 0; branch = 0; call = 0; ret = 0; err_clr = 0;
        BusMuxOut = '0;
        model_reset();
        @(negedge clock);
        clear = 1'b0;
        check_en = 1'b1;
        pin("reset", 32'h100, 0, 0);
        check("reset_empty", 32'(ras_empty), 32'd1);
        check("reset_full", 32'(ras_full), 32'd0);

        // Reset / increment
        tick(0, 1, 0, 0, 0, 0, 0); pin("inc1", 32'h101, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0); pin("inc2", 32'h102, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0); pin("inc3", 32'h103, 0, 0);
        do_clear();
        pin("after_clear", 32'h100, 0, 0);

        // Branch and load
        tick(1, 0, 0, 0, 0, 0, 32'h200);
        tick(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0); pin("branch_back", 32'h1F0, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 32'h0);         pin("load_wins", 32'h0, 0, 0);

        // Call / return nesting
        tick(1, 0, 0, 0, 0, 0, 32'h10);
        tick(0, 0, 0, 1, 0, 0, 32'h20);
        tick(0, 0, 0, 1, 0, 0, 32'h30);
        tick(0, 0, 0, 1, 0, 0, 32'h40); pin("nest_calls", 32'h40, 3, 0);
        tick(0, 0, 0, 0, 1, 0, 0);      pin("nest_ret1", 32'h30, 2, 0);
        tick(0, 0, 0, 0, 1, 0, 0);      pin("nest_ret2", 32'h20, 1, 0);
        tick(0, 0, 0, 0, 1, 0, 0);      pin("nest_ret3", 32'h10, 0, 0);
        check("nest_empty", 32'(ras_empty), 32'd1);

        // Overflow
        tick(1, 0, 0, 0, 0, 0, 32'h1);
        for (int i = 2; i <= 6; i++) tick(0, 0, 0, 1, 0, 0, 32'(i));
        pin("ovf", 32'h6, 4, 1);
        check("ovf_full", 32'(ras_full), 32'd1);
        tick(0, 0, 0, 0, 1, 0, 0); pin("ovf_ret1", 32'h5, 3, 1);
        tick(0, 0, 0, 0, 1, 0, 0); pin("ovf_ret2", 32'h4, 2, 1);
        tick(0, 0, 0, 0, 1, 0, 0); pin("ovf_ret3", 32'h3, 1, 1);
        tick(0, 0, 0, 0, 1, 0, 0); pin("ovf_ret4", 32'h2, 0, 1);

        // Underflow and conflict
        do_clear();
        tick(0, 0, 0, 0, 1, 0, 0);      pin("unf", 32'h100, 0, 1);
        tick(0, 0, 0, 0, 0, 1, 0);      pin("errclr", 32'h100, 0, 0);
        tick(0, 0, 0, 1, 0, 0, 32'h50); pin("call1", 32'h50, 1, 0);
        tick(0, 0, 0, 1, 1, 0, 32'h60); pin("conflict", 32'h100, 0, 1);
        tick(0, 0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 1, 0);      pin("clr_vs_unf", 32'h100, 0, 1);

        // Wrap
        tick(0, 0, 0, 0, 0, 1, 0);
        tick(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        tick(0, 1, 0, 0, 0, 0, 0);      pin("wrap", 32'h0, 0, 0);

        // Random commands, including occasional asynchronous clears
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_clear();
            end else begin
                tick($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 40,
                     $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                     ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)));
            end
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
